// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict redirect and statistics
module branch_predictor #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_BITS  = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  PCF,
   output logic                   PredTakenF,
   output logic [ADDR_WIDTH-1:0]  PredTargetF,
   input  logic                   BranchE,
   input  logic                   FlushE,
   input  logic [ADDR_WIDTH-1:0]  PCE,
   input  logic                   PCSrcE,
   input  logic [ADDR_WIDTH-1:0]  PCTargetE,
   input  logic                   PredTakenE,
   input  logic [ADDR_WIDTH-1:0]  PredTargetE,
   output logic                   MispredictE,
   output logic [ADDR_WIDTH-1:0]  RedirectPCE,
   output logic [COUNT_WIDTH-1:0] BranchCount,
   output logic [COUNT_WIDTH-1:0] MispredCount
);

   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
   localparam int ENTRIES  = 1 << INDEX_BITS;

   logic                  valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];

   logic [INDEX_BITS-1:0] idx_f, idx_e;
   logic [TAG_BITS-1:0]   tag_f, tag_e;
   logic                  hit_f, hit_e, upd;
   logic                  unused_pc_low;

   assign idx_f = PCF[INDEX_BITS+1:2];
   assign tag_f = PCF[ADDR_WIDTH-1:INDEX_BITS+2];
   assign idx_e = PCE[INDEX_BITS+1:2];
   assign tag_e = PCE[ADDR_WIDTH-1:INDEX_BITS+2];
   assign unused_pc_low = ^{PCF[1:0], PCE[1:0]};

   // Lookup reads registered state only, so a same-cycle update is seen next cycle.
   assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign PredTakenF  = hit_f && ctr_q[idx_f][1];
   assign PredTargetF = PredTakenF ? target_q[idx_f] : '0;

   assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign upd   = BranchE && !FlushE && !rst;

   assign MispredictE = BranchE && !FlushE &&
                        ((PCSrcE != PredTakenE) ||
                         (PCSrcE && PredTakenE && (PredTargetE != PCTargetE)));
   assign RedirectPCE = PCSrcE ? PCTargetE : PCE + ADDR_WIDTH'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         BranchCount  <= '0;
         MispredCount <= '0;
      end else if (upd) begin
         if (hit_e) begin
            if (PCSrcE) begin
               if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
               target_q[idx_e] <= PCTargetE;
            end else if (ctr_q[idx_e] != 2'b00) begin
               ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
            end
         end else if (PCSrcE) begin
            // Taken miss evicts whatever aliased entry was resident.
            valid_q[idx_e]  <= 1'b1;
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= PCTargetE;
            ctr_q[idx_e]    <= 2'b10;
         end
         if (BranchCount != '1) BranchCount <= BranchCount + COUNT_WIDTH'(1);
         if (MispredictE && (MispredCount != '1)) MispredCount <= MispredCount + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   PCF;
   logic          PredTakenF;
   logic [31:0]   PredTargetF;
   logic          BranchE, FlushE, PCSrcE, PredTakenE;
   logic [31:0]   PCE, PCTargetE, PredTargetE;
   logic          MispredictE;
   logic [31:0]   RedirectPCE;
   logic [CW-1:0] BranchCount, MispredCount;

   branch_predictor #(.ADDR_WIDTH(32), .INDEX_BITS(4), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
      .BranchE(BranchE), .FlushE(FlushE), .PCE(PCE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
      .RedirectPCE(RedirectPCE), .BranchCount(BranchCount), .MispredCount(MispredCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;
   exp_t sbq[$];

   int n_checks = 0;
   int n_pass   = 0;

   // reference table
   logic          m_valid [16];
   logic [25:0]   m_tag   [16];
   logic [31:0]   m_tgt   [16];
   logic [1:0]    m_ctr   [16];
   logic [CW-1:0] m_bc, m_mc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0: return {31'b0, PredTakenF};
         1: return PredTargetF;
         2: return {31'b0, MispredictE};
         3: return RedirectPCE;
         4: return {{(32-CW){1'b0}}, BranchCount};
         default: return {{(32-CW){1'b0}}, MispredCount};
      endcase
   endfunction

   task automatic lit(input string name, input int sel, input logic [31:0] exp);
      sbq.push_back('{name, sel, exp});
   endtask

   task automatic set_e(input logic br, input logic fl, input logic [31:0] pce, input logic src,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
      BranchE = br; FlushE = fl; PCE = pce; PCSrcE = src;
      PCTargetE = tgt; PredTakenE = pt; PredTargetE = ptg;
   endtask

   task automatic idle(input logic [31:0] pcf);
      PCF = pcf;
      set_e(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Push model expectations, compare everything queued, then advance one clock.
   task automatic step();
      logic [3:0]  fi, ei;
      logic        hit, pt, mp, hite, upd;
      logic [31:0] ptg, rp;
      exp_t        e;
      #2;
      fi  = PCF[5:2];
      hit = m_valid[fi] && (m_tag[fi] == PCF[31:6]);
      pt  = hit && m_ctr[fi][1];
      ptg = pt ? m_tgt[fi] : 32'h0;
      mp  = BranchE && !FlushE && ((PCSrcE != PredTakenE) ||
            (PCSrcE && PredTakenE && (PredTargetE != PCTargetE)));
      rp  = PCSrcE ? PCTargetE : PCE + 32'd4;
      lit("pred_taken_f", 0, {31'b0, pt});
      lit("pred_target_f", 1, ptg);
      lit("mispredict_e", 2, {31'b0, mp});
      lit("redirect_pc_e", 3, rp);
      lit("branch_count", 4, {{(32-CW){1'b0}}, m_bc});
      lit("mispred_count", 5, {{(32-CW){1'b0}}, m_mc});
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check(e.name, observe(e.sel), e.exp);
      end
      @(posedge clk);
      ei   = PCE[5:2];
      hite = m_valid[ei] && (m_tag[ei] == PCE[31:6]);
      upd  = BranchE && !FlushE && !rst;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
         end
         m_bc = '0; m_mc = '0;
      end else if (upd) begin
         if (hite && PCSrcE) begin
            if (m_ctr[ei] < 2'b11) m_ctr[ei] = m_ctr[ei] + 2'd1;
            m_tgt[ei] = PCTargetE;
         end else if (hite) begin
            if (m_ctr[ei] > 2'b00) m_ctr[ei] = m_ctr[ei] - 2'd1;
         end else if (PCSrcE) begin
            m_valid[ei] = 1'b1; m_tag[ei] = PCE[31:6]; m_tgt[ei] = PCTargetE; m_ctr[ei] = 2'b10;
         end
         if (m_bc != '1) m_bc = m_bc + 1'b1;
         if (mp && m_mc != '1) m_mc = m_mc + 1'b1;
      end
      #1;
   endtask

   logic [31:0] pcs [6];

   initial begin
      pcs = '{32'h100, 32'h140, 32'h104, 32'h200, 32'h1C0, 32'hFFFF_FFFC};
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
      end
      m_bc = '0; m_mc = '0;
      rst = 1'b1;
      idle(32'h100);
      @(posedge clk); #1;
      step();
      rst = 1'b0;

      idle(32'h100);
      lit("rst_pt", 0, 0); lit("rst_ptg", 1, 0); lit("rst_bc", 4, 0); lit("rst_mc", 5, 0);
      step();

      set_e(1, 0, 32'h100, 1, 32'h80, 0, 32'h0);
      lit("alloc_mp", 2, 1); lit("alloc_rp", 3, 32'h80);
      step();
      idle(32'h100);
      lit("alloc_pt", 0, 1); lit("alloc_ptg", 1, 32'h80); lit("alloc_bc", 4, 1); lit("alloc_mc", 5, 1);
      step();

      for (int i = 0; i < 3; i++) begin
         set_e(1, 0, 32'h100, 1, 32'h80, 1, 32'h80);
         lit("sat_mp", 2, 0);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         set_e(1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
         lit("nt_rp", 3, 32'h104);
         step();
      end
      idle(32'h100);
      lit("weak_nt_pt", 0, 0);
      step();

      set_e(1, 0, 32'h140, 1, 32'h200, 0, 32'h0);
      step();
      idle(32'h100);
      lit("alias_old_pt", 0, 0);
      step();
      idle(32'h140);
      lit("alias_new_ptg", 1, 32'h200);
      step();

      set_e(1, 0, 32'h140, 1, 32'h90, 1, 32'h80);
      lit("wrong_tgt_mp", 2, 1); lit("wrong_tgt_rp", 3, 32'h90);
      step();
      idle(32'h140);
      lit("wrong_tgt_upd", 1, 32'h90);
      step();
      set_e(1, 1, 32'h140, 0, 32'h0, 1, 32'h90);
      lit("flush_mp", 2, 0);
      step();

      PCF = 32'h140;
      set_e(1, 0, 32'h140, 1, 32'hA0, 1, 32'h90);
      lit("same_cyc_old", 1, 32'h90);
      step();
      idle(32'h140);
      lit("same_cyc_new", 1, 32'hA0);
      step();

      rst = 1'b1;
      PCF = 32'h140;
      set_e(1, 0, 32'h140, 1, 32'hB0, 1, 32'hA0);
      step();
      rst = 1'b0;
      idle(32'h140);
      lit("rst_upd_pt", 0, 0); lit("rst_upd_bc", 4, 0); lit("rst_upd_mc", 5, 0);
      step();

      set_e(1, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
      lit("wrap_rp", 3, 32'h0); lit("wrap_mp", 2, 0);
      step();

      for (int n = 0; n < 300; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         PCF = pcs[$urandom_range(0, 5)];
         set_e($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, pcs[$urandom_range(0, 5)],
               1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 3)) * 32'h10,
               1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 3)) * 32'h10);
         step();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage pipelined core.
- Fetch stage: combinational direction and target prediction from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Execute stage: takes the resolved outcome from the flags/branch-resolution logic (PCSrcE) and updates the table, raises a mispredict redirect for the hazard unit, and keeps prediction statistics counters.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- INDEX_BITS, 4, log2 of table entries (16 entries).
- COUNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- PCF  input  ADDR_WIDTH  fetch-stage PC to predict.
- PredTakenF  output  1  predict taken for PCF.
- PredTargetF  output  ADDR_WIDTH  predicted target for PCF (0 when PredTakenF=0).
- BranchE  input  1  a B-type instruction is valid in execute.
- FlushE  input  1  execute-stage instruction is squashed; blocks update.
- PCE  input  ADDR_WIDTH  PC of the execute-stage instruction.
- PCSrcE  input  1  resolved outcome, 1 = taken.
- PCTargetE  input  ADDR_WIDTH  resolved branch target.
- PredTakenE  input  1  PredTakenF carried down the pipeline to E.
- PredTargetE  input  ADDR_WIDTH  PredTargetF carried down the pipeline to E.
- MispredictE  output  1  redirect fetch and flush the younger stages.
- RedirectPCE  output  ADDR_WIDTH  correct next PC on mispredict.
- BranchCount  output  COUNT_WIDTH  number of resolved branches.
- MispredCount  output  COUNT_WIDTH  number of mispredicted branches.

Behaviour:

Table and addressing:
- Table: 2^INDEX_BITS entries, each {valid, tag[ADDR_WIDTH-INDEX_BITS-2], target[ADDR_WIDTH], ctr[2]}.
- Index = PC[INDEX_BITS+1:2]; tag = PC[ADDR_WIDTH-1:INDEX_BITS+2]. PC[1:0] is ignored.

Reset (rst=1 at a rising edge):
- All valid=0, all ctr=2'b01 (weakly not-taken), targets=0.
- BranchCount=0, MispredCount=0.
- rst takes priority over any same-cycle update.
- After reset, PredTakenF=0 for every PC. MispredictE depends only on the E inputs.

Fetch lookup (combinational, zero latency):
- hitF = valid[idxF] & (tag[idxF] == tagF).
- PredTakenF = hitF & ctr[idxF][1].
- PredTargetF = PredTakenF ? target[idxF] : 0.

Update enable:
- upd = BranchE & ~FlushE & ~rst. Table and counters change only when upd=1.

Update on hit (hitE):
- Taken: ctr saturating increment, max 2'b11; target <= PCTargetE.
- Not taken: ctr saturating decrement, min 2'b00; target unchanged.

Update on miss:
- Taken: allocate the entry, overwriting any resident entry: valid=1, tag=tagE, target=PCTargetE, ctr=2'b10.
- Not taken: no change.

Mispredict (combinational):
- MispredictE = BranchE & ~FlushE & ((PCSrcE != PredTakenE) | (PCSrcE & PredTakenE & (PredTargetE != PCTargetE))).
- RedirectPCE = PCSrcE ? PCTargetE : PCE + 4. Addition wraps modulo 2^ADDR_WIDTH.
- RedirectPCE is valid only when MispredictE=1; otherwise it still shows the same expression.

Statistics:
- On upd: BranchCount += 1.
- On upd & MispredictE: MispredCount += 1.
- Both counters saturate at all-ones and never wrap.

Simultaneous lookup/update:
- When the same index is read and written in the same cycle, the fetch lookup returns the pre-update contents (no bypass).
- The new value is visible from the next cycle.

Other cases:
- FlushE=1 together with BranchE=1: no update, no count, MispredictE=0.
- Non-branch instructions (BranchE=0), including JAL: no effect. JAL redirect is handled outside this block.

Test Plan:
1. Reset, then PCF=0x100 -> PredTakenF=0, PredTargetF=0; BranchCount=0, MispredCount=0.
2. BranchE=1, PCE=0x100, PCSrcE=1, PCTargetE=0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80; BranchCount=1, MispredCount=1.
3. Same entry resolved taken 3 more times with correct predictions (PredTakenE=1, PredTargetE=0x80) -> ctr saturates at 11, MispredictE=0. Then two not-taken resolutions -> ctr goes 10, then 01. PCF=0x100 then gives PredTakenF=0. On each not-taken resolution, RedirectPCE=0x104.
4. Aliasing: PCE=0x140 (same index, different tag) resolves taken to 0x200 -> entry replaced. PCF=0x100 misses (PredTakenF=0); PCF=0x140 gives PredTargetF=0x200.
5. Wrong-target: PredTakenE=1, PredTargetE=0x80, PCSrcE=1, PCTargetE=0x90 -> MispredictE=1, RedirectPCE=0x90, target updated to 0x90. BranchE=1 with FlushE=1 -> MispredictE=0, counters unchanged.
6. Same-cycle: update to 0x100's entry while PCF=0x100 -> fetch outputs the old prediction that cycle and the new one the next. rst asserted during an update -> table cleared; counters read 0 next cycle.
